// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write/status bundle for the boot-time instruction loader.
// The loader uses the slave modport; the byte source / system side uses master.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 28
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  core_rst;
  logic                  done;
  logic                  error;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Streams a checksummed little-endian image into imem and holds the core in reset
// until the whole image has been written and verified.
//
// state | meaning
// INIT  | one idle cycle after reset, stream not accepted
// HDR   | collecting the 4-byte word count
// DATA  | assembling payload words and writing them to imem
// CHK   | waiting for the checksum byte
// DONE  | image verified, core released
// ERR   | oversize image or bad checksum, core held in reset
module imem_loader #(
  parameter int ADDR_WIDTH = 28
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);
  typedef enum logic [2:0] {INIT, HDR, DATA, CHK, DONE, ERR} state_t;

  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [7:0]            sum_q, sum_d;
  logic [1:0]            byte_q, byte_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [23:0]           asm_q, asm_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;

  logic                  accept;
  logic [31:0]           cnt_full;

  assign bus.rx_ready   = (state_q == HDR) || (state_q == DATA) || (state_q == CHK);
  assign accept         = bus.rx_valid && bus.rx_ready;
  assign cnt_full       = {bus.rx_data, cnt_q[31:8]};

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_rst   = (state_q != DONE);
  assign bus.done       = (state_q == DONE);
  assign bus.error      = (state_q == ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      sum_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      asm_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      asm_q   <= asm_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    byte_d  = byte_q;
    word_d  = word_q;
    addr_d  = addr_q;
    asm_d   = asm_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;

    unique case (state_q)
      INIT: state_d = HDR;
      HDR: begin
        if (accept) begin
          cnt_d  = cnt_full;
          sum_d  = sum_q + bus.rx_data;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            // Compare one bit wider so a count of exactly 2**ADDR_WIDTH is still legal.
            if ({1'b0, cnt_full} > MAX_WORDS) state_d = ERR;
            else if (cnt_full == 32'd0)      state_d = CHK;
            else                             state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          sum_d  = sum_q + bus.rx_data;
          byte_d = byte_q + 2'd1;
          asm_d  = {bus.rx_data, asm_q[23:8]};
          if (byte_q == 2'd3) begin
            wdata_d = {bus.rx_data, asm_q};
            addr_d  = word_q;
            we_d    = 1'b1;
            word_d  = word_q + ADDR_WIDTH'(1);
            if (33'(word_q) == 33'(cnt_q) - 33'd1) state_d = CHK;
          end
        end
      end
      CHK: begin
        if (accept) state_d = (bus.rx_data == sum_q) ? DONE : ERR;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of whole-stream vectors plus hand-written
// sequences for reset timing, write latency, mid-load reset and size boundaries.
module tb_imem_loader;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(28)) bus28();
  imem_loader_if #(.ADDR_WIDTH(4))  bus4();

  assign bus28.rx_valid = rx_valid;
  assign bus28.rx_data  = rx_data;
  assign bus4.rx_valid  = rx_valid;
  assign bus4.rx_data   = rx_data;

  imem_loader #(.ADDR_WIDTH(28)) u_dut28 (.clk(clk), .rst(rst_n), .bus(bus28));
  imem_loader #(.ADDR_WIDTH(4))  u_dut4  (.clk(clk), .rst(rst_n), .bus(bus4));

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t q4[$];
  wr_t q28[$];

  always @(negedge clk) begin
    if (bus4.imem_we === 1'b1)  q4.push_back('{addr: 32'(bus4.imem_addr), data: bus4.imem_wdata});
    if (bus28.imem_we === 1'b1) q28.push_back('{addr: 32'(bus28.imem_addr), data: bus28.imem_wdata});
  end

  typedef struct {
    string       name;
    logic [7:0]  b [16];
    int          len;
    int          nwr;
    logic [31:0] w [4];
    bit          exp_done;
    bit          exp_err;
    int          gapmax;
    bit          chk28;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  cs;
  logic [31:0] wv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q4.delete();
    q28.delete();
    rst_n = 1'b1;
  endtask

  // Called and returns 1 time unit after a rising edge; leaves rx_valid high so
  // back-to-back calls stream one byte per cycle.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit use28);
    int k;
    bit rdy;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    k   = 0;
    rdy = 1'b0;
    while (!rdy && k < 50) begin
      @(negedge clk);
      rdy = use28 ? bus28.rx_ready : bus4.rx_ready;
      @(posedge clk);
      #1;
      k++;
    end
    if (!rdy) begin
      n_vec++;
      n_err++;
      $display("FAIL handshake: byte %h got no rx_ready within 50 cycles", b);
    end
  endtask

  task automatic apply_vec(input int v);
    do_reset();
    for (int i = 0; i < vecs[v].len; i++)
      send_byte(vecs[v].b[i], (vecs[v].gapmax > 0) ? int'($urandom_range(0, vecs[v].gapmax)) : 0, 1'b0);
    chk({vecs[v].name, " done_next"},  32'(bus4.done),  32'(vecs[v].exp_done));
    chk({vecs[v].name, " error_next"}, 32'(bus4.error), 32'(vecs[v].exp_err));
    rx_data = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    @(negedge clk);
    chk({vecs[v].name, " nwr"},      32'(q4.size()),     32'(vecs[v].nwr));
    for (int i = 0; i < vecs[v].nwr; i++) begin
      if (i < q4.size()) begin
        chk({vecs[v].name, " addr"}, q4[i].addr, 32'(i));
        chk({vecs[v].name, " data"}, q4[i].data, vecs[v].w[i]);
      end
    end
    chk({vecs[v].name, " done"},     32'(bus4.done),     32'(vecs[v].exp_done));
    chk({vecs[v].name, " error"},    32'(bus4.error),    32'(vecs[v].exp_err));
    chk({vecs[v].name, " core_rst"}, 32'(bus4.core_rst), 32'(!vecs[v].exp_done));
    chk({vecs[v].name, " rx_ready"}, 32'(bus4.rx_ready), 32'd0);
    if (vecs[v].chk28) begin
      chk({vecs[v].name, " nwr28"},  32'(q28.size()),    32'(vecs[v].nwr));
      chk({vecs[v].name, " done28"}, 32'(bus28.done),    32'(vecs[v].exp_done));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{name: "nominal",
                b: '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                     8'h13, 8'h01, 8'hA0, 8'h00, 8'h99, 8'h00, 8'h00, 8'h00},
                len: 13, nwr: 2, w: '{32'h00500093, 32'h00A00113, 32'h0, 32'h0},
                exp_done: 1'b1, exp_err: 1'b0, gapmax: 0, chk28: 1'b1};
    vecs[1] = '{name: "zero_len",
                b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                len: 5, nwr: 0, w: '{32'h0, 32'h0, 32'h0, 32'h0},
                exp_done: 1'b1, exp_err: 1'b0, gapmax: 0, chk28: 1'b1};
    vecs[2] = '{name: "bad_sum",
                b: '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                     8'h13, 8'h01, 8'hA0, 8'h00, 8'h98, 8'h00, 8'h00, 8'h00},
                len: 13, nwr: 2, w: '{32'h00500093, 32'h00A00113, 32'h0, 32'h0},
                exp_done: 1'b0, exp_err: 1'b1, gapmax: 0, chk28: 1'b1};
    vecs[3] = '{name: "oversize17",
                b: '{8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                len: 4, nwr: 0, w: '{32'h0, 32'h0, 32'h0, 32'h0},
                exp_done: 1'b0, exp_err: 1'b1, gapmax: 0, chk28: 1'b0};
    vecs[4] = '{name: "gaps",
                b: '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                     8'h13, 8'h01, 8'hA0, 8'h00, 8'h99, 8'h00, 8'h00, 8'h00},
                len: 13, nwr: 2, w: '{32'h00500093, 32'h00A00113, 32'h0, 32'h0},
                exp_done: 1'b1, exp_err: 1'b0, gapmax: 5, chk28: 1'b1};
    vecs[5] = '{name: "one_word",
                b: '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                     8'h39, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                len: 9, nwr: 1, w: '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0},
                exp_done: 1'b1, exp_err: 1'b0, gapmax: 0, chk28: 1'b1};

    // Asynchronous reset values, sampled between edges.
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst rx_ready",   32'(bus4.rx_ready), 32'd0);
    chk("rst imem_we",    32'(bus4.imem_we),  32'd0);
    chk("rst imem_addr",  32'(bus4.imem_addr), 32'd0);
    chk("rst imem_wdata", bus4.imem_wdata,    32'd0);
    chk("rst core_rst",   32'(bus4.core_rst), 32'd1);
    chk("rst done",       32'(bus4.done),     32'd0);
    chk("rst error",      32'(bus4.error),    32'd0);

    // First byte is held valid across release: it must be taken on the 2nd edge only.
    rx_valid = 1'b1;
    rx_data  = 8'h02;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("init rx_ready", 32'(bus4.rx_ready), 32'd0);
    @(negedge clk);
    chk("hdr rx_ready",  32'(bus4.rx_ready), 32'd1);
    @(posedge clk);
    #1;
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h93, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h50, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    chk("lat w0 we",    32'(bus4.imem_we),   32'd1);
    chk("lat w0 addr",  32'(bus4.imem_addr), 32'd0);
    chk("lat w0 data",  bus4.imem_wdata,     32'h00500093);
    send_byte(8'h13, 0, 1'b0);
    chk("lat w0 pulse", 32'(bus4.imem_we),   32'd0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'hA0, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    chk("lat w1 we",    32'(bus4.imem_we),   32'd1);
    chk("lat w1 addr",  32'(bus4.imem_addr), 32'd1);
    chk("lat w1 data",  bus4.imem_wdata,     32'h00A00113);
    chk("lat pre done", 32'(bus4.done),      32'd0);
    send_byte(8'h99, 0, 1'b0);
    rx_valid = 1'b0;
    chk("lat done",     32'(bus4.done),      32'd1);
    chk("lat core_rst", 32'(bus4.core_rst),  32'd0);
    chk("lat rx_ready", 32'(bus4.rx_ready),  32'd0);
    chk("lat nwr",      32'(q4.size()),      32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst2 done",     32'(bus4.done),      32'd0);
    chk("rst2 core_rst", 32'(bus4.core_rst),  32'd1);
    chk("rst2 addr",     32'(bus4.imem_addr), 32'd0);
    chk("rst2 wdata",    bus4.imem_wdata,     32'd0);

    for (int v = 0; v < NV; v++) apply_vec(v);

    // Reset after the 6th byte discards the partial word, then a full replay.
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(vecs[0].b[i], 0, 1'b0);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst rx_ready", 32'(bus4.rx_ready), 32'd0);
    chk("midrst core_rst", 32'(bus4.core_rst), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst nowr", 32'(q4.size()), 32'd0);
    apply_vec(0);

    // Largest legal image for ADDR_WIDTH=4: 16 words through address 15.
    do_reset();
    cs = 8'h00;
    send_byte(8'h10, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    cs = 8'h10;
    for (int w = 0; w < 16; w++) begin
      wv = 32'h01020304 * 32'(w + 1);
      for (int k = 0; k < 4; k++) begin
        send_byte(wv[8*k +: 8], 0, 1'b0);
        cs = cs + wv[8*k +: 8];
      end
    end
    send_byte(cs, 0, 1'b0);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("n16 nwr",  32'(q4.size()), 32'd16);
    for (int w = 0; w < 16; w++) begin
      if (w < q4.size()) begin
        chk("n16 addr", q4[w].addr, 32'(w));
        chk("n16 data", q4[w].data, 32'h01020304 * 32'(w + 1));
      end
    end
    chk("n16 done", 32'(bus4.done), 32'd1);

    // ADDR_WIDTH=28 boundary: 2**28+1 words rejected, exactly 2**28 accepted.
    do_reset();
    send_byte(8'h01, 0, 1'b1);
    send_byte(8'h00, 0, 1'b1);
    send_byte(8'h00, 0, 1'b1);
    send_byte(8'h10, 0, 1'b1);
    rx_valid = 1'b0;
    chk("aw28 over error",    32'(bus28.error),    32'd1);
    chk("aw28 over rx_ready", 32'(bus28.rx_ready), 32'd0);
    do_reset();
    send_byte(8'h00, 0, 1'b1);
    send_byte(8'h00, 0, 1'b1);
    send_byte(8'h00, 0, 1'b1);
    send_byte(8'h10, 0, 1'b1);
    rx_valid = 1'b0;
    chk("aw28 max error",    32'(bus28.error),    32'd0);
    chk("aw28 max rx_ready", 32'(bus28.rx_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
